// File: rtl/memory_bus_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared memory port.
//
// Signals
//   r0_*  : requester 0 (core) read/write request level, address, write data,
//           read data and one-cycle response pulse.
//   r1_*  : the same for requester 1 (controller loader/debug master).
//   mem_* : the single shared memory port. Request levels, address and write
//           data go to memory; read data and a one-cycle response come back.
//
// Modports
//   master : the arbiter's view. It serves the requesters and masters memory.
//   slave  : the environment's view (requesters and memory together).
interface memory_bus_arbiter_if #(
    parameter int unsigned BUS_WIDTH = 32
);
    // Requester 0
    logic                 r0_read;
    logic                 r0_write;
    logic [BUS_WIDTH-1:0] r0_address;
    logic [BUS_WIDTH-1:0] r0_write_data;
    logic [BUS_WIDTH-1:0] r0_read_data;
    logic                 r0_response;

    // Requester 1
    logic                 r1_read;
    logic                 r1_write;
    logic [BUS_WIDTH-1:0] r1_address;
    logic [BUS_WIDTH-1:0] r1_write_data;
    logic [BUS_WIDTH-1:0] r1_read_data;
    logic                 r1_response;

    // Shared memory port
    logic                 mem_read;
    logic                 mem_write;
    logic [BUS_WIDTH-1:0] mem_address;
    logic [BUS_WIDTH-1:0] mem_write_data;
    logic [BUS_WIDTH-1:0] mem_read_data;
    logic                 mem_response;

    modport master (
        input  r0_read, r0_write, r0_address, r0_write_data,
        output r0_read_data, r0_response,
        input  r1_read, r1_write, r1_address, r1_write_data,
        output r1_read_data, r1_response,
        output mem_read, mem_write, mem_address, mem_write_data,
        input  mem_read_data, mem_response
    );

    modport slave (
        output r0_read, r0_write, r0_address, r0_write_data,
        input  r0_read_data, r0_response,
        output r1_read, r1_write, r1_address, r1_write_data,
        input  r1_read_data, r1_response,
        input  mem_read, mem_write, mem_address, mem_write_data,
        output mem_read_data, mem_response
    );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Two-master arbiter sharing one request/response memory port between the core
// (requester 0) and the controller's internal memory master (requester 1).
// One requester is served at a time; simultaneous requests alternate
// round-robin. The grant is held until memory answers or the watchdog fires,
// then one RELEASE cycle separates transactions.
//
// Ports
//   clk          : single clock, rising edge.
//   reset        : synchronous, active-high.
//   bus          : memory_bus_arbiter_if.master (requester and memory signals).
//   grant        : index of the current or most recent owner.
//   busy         : high while a transaction is outstanding on memory.
//   timeout_flag : sticky, set when the watchdog completes a transaction;
//                  cleared only by reset.
//
// Parameters
//   BUS_WIDTH      : address/data width.
//   TIMEOUT_CYCLES : BUSY cycles before forced completion, 0 disables.
//   TIMEOUT_DATA   : read data returned on a forced completion.
module memory_bus_arbiter #(
    parameter int unsigned          BUS_WIDTH      = 32,
    parameter int unsigned          TIMEOUT_CYCLES = 1024,
    parameter logic [BUS_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    memory_bus_arbiter_if.master  bus,
    output logic                  grant,
    output logic                  busy,
    output logic                  timeout_flag
);

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StRelease
    } state_e;

    state_e               state_q;
    logic                 last_grant_q;
    logic                 grant_q;
    logic                 busy_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [BUS_WIDTH-1:0] wdata_q;
    logic                 flag_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 act0;
    logic                 act1;
    logic                 pick;
    logic                 pick_read;
    logic                 mem_done;
    logic                 wdog_hit;
    logic                 complete;
    logic [BUS_WIDTH-1:0] resp_data;

    always_comb begin
        act0 = bus.r0_read | bus.r0_write;
        act1 = bus.r1_read | bus.r1_write;
        // On a tie the requester that was not served last wins; otherwise
        // whichever one is active (act1 alone selects 1, act0 alone selects 0).
        pick = (act0 && act1) ? ~last_grant_q : act1;
        // Read has priority when a requester raises both read and write.
        pick_read = pick ? bus.r1_read : bus.r0_read;

        // Responses are suppressed during reset so a transaction killed by
        // reset never reports completion.
        mem_done = (state_q == StBusy) && bus.mem_response && !reset;
        // A real memory answer in the limit cycle wins over the watchdog.
        wdog_hit = WDOG_EN && (state_q == StBusy) && (cnt_q == CNT_LIMIT)
                   && !bus.mem_response && !reset;
        complete  = mem_done | wdog_hit;
        resp_data = mem_done ? bus.mem_read_data : TIMEOUT_DATA;
    end

    // Completion is passed through combinationally: zero-latency response.
    assign bus.r0_response  = complete && (grant_q == 1'b0);
    assign bus.r1_response  = complete && (grant_q == 1'b1);
    assign bus.r0_read_data = bus.r0_response ? resp_data : '0;
    assign bus.r1_read_data = bus.r1_response ? resp_data : '0;

    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign grant              = grant_q;
    assign busy               = busy_q;
    assign timeout_flag       = flag_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            flag_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (act0 || act1) begin
                        grant_q     <= pick;
                        addr_q      <= pick ? bus.r1_address : bus.r0_address;
                        wdata_q     <= pick ? bus.r1_write_data : bus.r0_write_data;
                        mem_read_q  <= pick_read;
                        mem_write_q <= !pick_read;
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (complete) begin
                        mem_read_q   <= 1'b0;
                        mem_write_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        last_grant_q <= grant_q;
                        if (wdog_hit) begin
                            flag_q <= 1'b1;
                        end
                        state_q <= StRelease;
                    end else begin
                        // Wraps harmlessly when the watchdog is disabled.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
